// File: rtl/opb_register_ppc2simulink_buffered.sv
// OPB slave register carrying a software-written word into fabric, with update strobe and write counter.
// Optional build macro PPC2SIM_DOUBLE_BUFFER_EN adds a staging register committed by a write to offset 0x8.
module opb_register_ppc2simulink_buffered #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter string       C_FAMILY      = "virtex6",
  parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  output logic [0:31] Sl_DBus,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic        Sl_xferAck,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [31:0] user_data_out,
  output logic        user_data_valid,
  output logic [31:0] write_count
);

  localparam bit C_CFG_OK = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && (C_FAMILY != "");

  localparam logic [5:0] W_DATA   = 6'd0;
  localparam logic [5:0] W_COUNT  = 6'd1;
  localparam logic [5:0] W_COMMIT = 6'd2;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rnw;
  logic [5:0]  r_word;
  logic [31:0] r_mask;
  logic [31:0] r_wdata;
  logic [31:0] r_user_data;
  logic        r_valid;
  logic [31:0] r_write_count;

  logic [31:0] w_addr;
  logic [31:0] w_offset;
  logic        w_hit;
  logic [31:0] w_mask;
  logic        w_ack;
  logic        w_wr;
  logic        w_data_wr;
  logic        w_commit;
  logic [31:0] w_merge_src;
  logic [31:0] w_merged;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Addresses below the base wrap to large offsets, so one unsigned compare covers both bounds.
  assign w_addr   = OPB_ABus;
  assign w_offset = w_addr - C_BASEADDR;
  assign w_hit    = OPB_select && (w_offset <= (C_HIGHADDR - C_BASEADDR));
  assign w_unused = ^{w_offset[31:8], w_offset[1:0], OPB_seqAddr, C_CFG_OK};

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 4; i++) begin
      w_mask[31-8*i -: 8] = {8{OPB_BE[i]}};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hit) w_next = S_ACK;
      S_ACK:   w_next = S_WAIT;
      S_WAIT:  if (!OPB_select) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are captured on the hit so the ack cycle works from stable copies.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      r_state <= S_IDLE;
      r_rnw   <= 1'b1;
      r_word  <= '0;
      r_mask  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_hit) begin
        r_rnw   <= OPB_RNW;
        r_word  <= w_offset[7:2];
        r_mask  <= w_mask;
        r_wdata <= OPB_DBus;
      end
    end
  end

  assign w_ack     = (r_state == S_ACK);
  assign w_wr      = w_ack && !r_rnw && (r_mask != 32'd0);
  assign w_data_wr = w_wr && (r_word == W_DATA);
  assign w_merged  = (w_merge_src & ~r_mask) | (r_wdata & r_mask);

`ifdef PPC2SIM_DOUBLE_BUFFER_EN
  logic [31:0] r_stage;

  assign w_commit    = w_wr && (r_word == W_COMMIT);
  assign w_merge_src = r_stage;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      r_stage       <= C_RESET_VALUE;
      r_user_data   <= C_RESET_VALUE;
      r_valid       <= 1'b0;
      r_write_count <= '0;
    end else begin
      r_valid <= w_commit;
      if (w_data_wr) r_stage <= w_merged;
      if (w_commit) begin
        r_user_data   <= r_stage;
        r_write_count <= r_write_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (r_word)
      W_DATA:  w_rdata = r_stage;
      W_COUNT: w_rdata = r_write_count;
      default: w_rdata = '0;
    endcase
  end
`else
  assign w_commit    = 1'b0;
  assign w_merge_src = r_user_data;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      r_user_data   <= C_RESET_VALUE;
      r_valid       <= 1'b0;
      r_write_count <= '0;
    end else begin
      r_valid <= w_data_wr;
      if (w_data_wr) begin
        r_user_data   <= w_merged;
        r_write_count <= r_write_count + 32'd1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (r_word)
      W_DATA:  w_rdata = r_user_data;
      W_COUNT: w_rdata = r_write_count;
      default: w_rdata = '0;
    endcase
  end
`endif

  // Read data only appears in the read ack cycle to keep the OR-combined bus clean.
  assign Sl_DBus         = (w_ack && r_rnw) ? w_rdata : 32'd0;
  assign Sl_xferAck      = w_ack;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = r_user_data;
  assign user_data_valid = r_valid;
  assign write_count     = r_write_count;

endmodule

// File: tb/tb_opb_register_ppc2simulink_buffered.sv
// Bench for opb_register_ppc2simulink_buffered: scoreboard of expected acks and update pulses vs a register-map model.
module tb_opb_register_ppc2simulink_buffered;

  localparam logic [31:0] BASE  = 32'h8000_1000;
  localparam logic [31:0] HIGH  = 32'h8000_10FF;
  localparam logic [31:0] RESET = 32'h5A5A_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_erracK, sl_retry, sl_toutsup, sl_xferack;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seqaddr = 1'b0;
  logic [31:0] user_data_out;
  logic        user_data_valid;
  logic [31:0] write_count;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_ack_q[$];
  logic [63:0] exp_upd_q[$];

  logic [31:0] m_data, m_stage, m_count;

  opb_register_ppc2simulink_buffered #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_RESET_VALUE(RESET)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .Sl_DBus(sl_dbus), .Sl_errAck(sl_erracK),
    .Sl_retry(sl_retry), .Sl_toutSup(sl_toutsup), .Sl_xferAck(sl_xferack),
    .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus), .OPB_RNW(rnw),
    .OPB_select(sel), .OPB_seqAddr(seqaddr), .user_data_out(user_data_out),
    .user_data_valid(user_data_valid), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT acks or pulses an update.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sl_xferack) begin
        if (exp_ack_q.size() == 0) check("unexpected_ack", 64'd1, 64'd0);
        else check("ack_dbus", {32'd0, sl_dbus}, {32'd0, exp_ack_q.pop_front()});
      end else begin
        check("idle_dbus_zero", {32'd0, sl_dbus}, 64'd0);
      end
      if (user_data_valid) begin
        if (exp_upd_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else check("update_data_count", {user_data_out, write_count}, exp_upd_q.pop_front());
      end
    end
  end

  task automatic model_reset();
    m_data = RESET;
    m_stage = RESET;
    m_count = 32'd0;
  endtask

  // Reference model of one transfer; returns whether it hits and whether an update pulse follows.
  task automatic model_xfer(input logic [31:0] addr, input bit is_rd, input logic [0:3] b,
                            input logic [31:0] d, output bit hit, output bit pulse);
    logic [31:0] off;
    logic [31:0] nv;
    off = addr - BASE;
    hit = (addr >= BASE) && (addr <= HIGH);
    pulse = 1'b0;
    if (!hit) return;
    if (is_rd) begin
      if (off[7:2] == 6'd0) begin
`ifdef PPC2SIM_DOUBLE_BUFFER_EN
        exp_ack_q.push_back(m_stage);
`else
        exp_ack_q.push_back(m_data);
`endif
      end else if (off[7:2] == 6'd1) exp_ack_q.push_back(m_count);
      else exp_ack_q.push_back(32'd0);
      return;
    end
    exp_ack_q.push_back(32'd0);
    if (b == 4'b0000) return;
`ifdef PPC2SIM_DOUBLE_BUFFER_EN
    nv = m_stage;
`else
    nv = m_data;
`endif
    for (int i = 0; i < 4; i++)
      if (b[i]) nv[31-8*i -: 8] = d[31-8*i -: 8];
`ifdef PPC2SIM_DOUBLE_BUFFER_EN
    if (off[7:2] == 6'd0) m_stage = nv;
    if (off[7:2] == 6'd2) begin
      m_data = m_stage;
      m_count = m_count + 32'd1;
      pulse = 1'b1;
    end
`else
    if (off[7:2] == 6'd0) begin
      m_data = nv;
      m_count = m_count + 32'd1;
      pulse = 1'b1;
    end
`endif
    if (pulse) exp_upd_q.push_back({m_data, m_count});
  endtask

  task automatic xfer(input logic [31:0] addr, input bit is_rd, input logic [0:3] b,
                      input logic [31:0] d, input int hold);
    bit hit, pulse;
    model_xfer(addr, is_rd, b, d, hit, pulse);
    @(negedge clk);
    abus = addr; rnw = is_rd; be = b; dbus = d; sel = 1'b1;
    if (hit) begin
      @(negedge clk);
      check("ack_latency", {63'd0, sl_xferack}, 64'd1);
      @(negedge clk);
      check("valid_latency", {63'd0, user_data_valid}, {63'd0, pulse});
      repeat (hold) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] offs [7];
    logic [31:0] a;
    offs[0] = 32'h0; offs[1] = 32'h4; offs[2] = 32'h8; offs[3] = 32'h10;
    offs[4] = 32'hFC; offs[5] = 32'h100; offs[6] = 32'hFFFF_FFFC;
    model_reset();

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_user_data", {32'd0, user_data_out}, {32'd0, RESET});
    check("rst_count", {32'd0, write_count}, 64'd0);
    check("rst_ack", {63'd0, sl_xferack}, 64'd0);
    check("rst_dbus", {32'd0, sl_dbus}, 64'd0);
    check("rst_valid", {63'd0, user_data_valid}, 64'd0);
    check("tied_low", {61'd0, sl_erracK, sl_retry, sl_toutsup}, 64'd0);

`ifdef PPC2SIM_DOUBLE_BUFFER_EN
    xfer(BASE, 1'b0, 4'b1111, 32'hCAFE_F00D, 0);
    check("dbuf_out_unchanged", {32'd0, user_data_out}, {32'd0, RESET});
    xfer(BASE, 1'b1, 4'b1111, 32'd0, 0);
    xfer(BASE + 32'h8, 1'b1, 4'b1111, 32'd0, 0);
    xfer(BASE + 32'h8, 1'b0, 4'b0001, 32'd0, 0);
    check("dbuf_commit_out", {32'd0, user_data_out}, 64'hCAFE_F00D);
    check("dbuf_commit_count", {32'd0, write_count}, 64'd1);
`else
    xfer(BASE, 1'b0, 4'b1111, 32'hDEAD_BEEF, 0);
    check("full_write_out", {32'd0, user_data_out}, 64'hDEAD_BEEF);
    check("full_write_count", {32'd0, write_count}, 64'd1);
    xfer(BASE, 1'b1, 4'b1111, 32'd0, 0);
    xfer(BASE, 1'b0, 4'b0101, 32'h1122_3344, 0);
    check("partial_be_out", {32'd0, user_data_out}, 64'hDE22_BE44);
    check("partial_be_count", {32'd0, write_count}, 64'd2);
    xfer(BASE, 1'b0, 4'b0000, 32'hFFFF_FFFF, 0);
    check("be0_out", {32'd0, user_data_out}, 64'hDE22_BE44);
    check("be0_count", {32'd0, write_count}, 64'd2);
    xfer(BASE + 32'h8, 1'b0, 4'b1111, 32'h1234_5678, 0);
`endif
    xfer(BASE, 1'b1, 4'b1111, 32'd0, 4);
    xfer(HIGH + 32'h4, 1'b1, 4'b1111, 32'd0, 0);
    xfer(BASE - 32'h4, 1'b0, 4'b1111, 32'hFFFF_FFFF, 0);
    xfer(BASE + 32'h10, 1'b1, 4'b1111, 32'd0, 0);
    xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'h0000_0055, 0);
    xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'd0, 0);

    // Counter wrap: preload the count register directly.
    @(negedge clk);
    force dut.r_write_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_write_count;
    m_count = 32'hFFFF_FFFF;
`ifdef PPC2SIM_DOUBLE_BUFFER_EN
    xfer(BASE + 32'h8, 1'b0, 4'b1000, 32'd0, 0);
`else
    xfer(BASE, 1'b0, 4'b1000, 32'hA500_0000, 0);
`endif
    check("count_wrap", {32'd0, write_count}, 64'd0);

    for (int n = 0; n < 150; n++) begin
      a = BASE + offs[$urandom_range(0, 6)];
      xfer(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
    end

    // Reset asserted inside the ack cycle of a committing write.
    @(negedge clk);
    abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'h0BAD_F00D; sel = 1'b1;
`ifdef PPC2SIM_DOUBLE_BUFFER_EN
    abus = BASE + 32'h8;
`endif
    exp_ack_q.push_back(32'd0);
    @(negedge clk);
    check("midop_ack_seen", {63'd0, sl_xferack}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midop_ack_drop", {63'd0, sl_xferack}, 64'd0);
    check("midop_user_data", {32'd0, user_data_out}, {32'd0, RESET});
    check("midop_count", {32'd0, write_count}, 64'd0);
    sel = 1'b0;
    model_reset();
    @(negedge clk);
    check("midop_no_valid", {63'd0, user_data_valid}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_user_data", {32'd0, user_data_out}, {32'd0, RESET});
    xfer(BASE, 1'b0, 4'b0011, 32'h0000_7777, 0);
    xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'd0, 0);

    repeat (4) @(negedge clk);
    check("ack_queue_drained", 64'(exp_ack_q.size()), 64'd0);
    check("upd_queue_drained", 64'(exp_upd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opb_register_ppc2simulink_buffered.md
Name: opb_register_ppc2simulink_buffered

Overview:
OPB slave register carrying data from software (PPC) into user fabric logic, the write-direction counterpart of the simulink2ppc readback registers. Software writes a 32-bit word with byte enables and may read it back. The block presents the word to user logic together with a one-cycle update strobe and a free-running write counter. It sits on the OPB bus beside the other per-register slaves at its own 256-byte window.

Parameters:
C_BASEADDR, 32'h00000000, first byte address of the slave window
C_HIGHADDR, 32'h000000FF, last byte address of the slave window
C_OPB_AWIDTH, 32, OPB address width; only 32 supported
C_OPB_DWIDTH, 32, OPB data width; only 32 supported
C_FAMILY, "virtex6", target family string; informational only
C_RESET_VALUE, 32'h00000000, value of user_data_out and staging register after reset

Ports:
OPB_Clk  in  1  single clock for bus and user side
OPB_Rst  in  1  asynchronous reset, active-low
Sl_DBus  out  [0:31]  read data; all zeros except during the read ack cycle
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge
OPB_ABus  in  [0:31]  byte address
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  bus select
OPB_seqAddr  in  1  ignored; bursts are not supported
user_data_out  out  [31:0]  register value to fabric; bit 31 = DBus[0]
user_data_valid  out  1  one-cycle pulse when user_data_out changes by a bus write
write_count  out  [31:0]  number of committed data writes

Behaviour:
- Reset: asserting OPB_Rst low clears everything immediately, regardless of clock.
  - Sl_xferAck = 0; Sl_DBus = 0; user_data_valid = 0.
  - user_data_out and the staging register = C_RESET_VALUE; write_count = 0.
  - FSM = IDLE.
  - A reset mid-transfer drops the ack and discards the pending write.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. The word offset is OPB_ABus[24:29] relative to base.
- Register map:
  - 0x0 DATA: read/write.
  - 0x4 COUNT: read-only; writes are acked and ignored.
  - 0x8 COMMIT: only with the macro; see Optional Feature.
  - Other offsets: acked, read 0, writes ignored.
- FSM:
  - IDLE -> ACK on a hit.
  - ACK: Sl_xferAck=1 for exactly one cycle. For reads, Sl_DBus carries the register value; for writes, the write is performed at the end of this cycle. ACK -> WAIT unconditionally.
  - WAIT -> IDLE when OPB_select=0; otherwise stay in WAIT with no re-ack.
  - A back-to-back transfer therefore requires select to drop for at least one cycle.
- Latency:
  - Hit sampled at edge N; Sl_xferAck high in cycle N+1.
  - Write effect (user_data_out, write_count, user_data_valid=1) visible from cycle N+2.
  - user_data_valid is high for exactly one cycle.
- Byte enables: each BE bit gates its byte independently. Partial writes merge with the current value. BE=0000 is still acked, updates nothing, and counts nothing.
- write_count: increments by 1 per DATA write (or per COMMIT with the macro) with at least one BE set. It wraps 0xFFFFFFFF -> 0 without saturation.
- Sl_DBus: forced 0 outside the ack cycle and on write acks, so the OR-bus stays clean.

Optional Feature:
Macro: PPC2SIM_DOUBLE_BUFFER_EN.
- Defined:
  - DATA writes land in the staging register only. Readback of 0x0 returns the staging register.
  - A write to 0x8 with any BE set copies staging to user_data_out, pulses user_data_valid, and increments write_count. Reads of 0x8 return 0.
- Not defined:
  - No staging register; DATA writes go directly to user_data_out.
  - 0x8 behaves as an unmapped offset.

Test Plan:
- Reset then idle: release OPB_Rst after 5 cycles, no select -> user_data_out=C_RESET_VALUE, write_count=0, Sl_xferAck=0, Sl_DBus=0.
- Full write/read (no macro): write 0xDEADBEEF to base+0, BE=1111 -> ack 1 cycle after select, user_data_out=0xDEADBEEF and valid pulse at N+2, count=1. Read base+0 -> Sl_DBus=0xDEADBEEF only in the ack cycle.
- Partial BE: from 0xDEADBEEF, write 0x11223344 with BE=0101 -> user_data_out=0xDE22BE44, count=2. Write with BE=0000 -> acked, value and count unchanged, no valid pulse.
- Select held / miss: select held 4 cycles on a hit -> exactly one ack. Address C_HIGHADDR+4 -> no ack. Read base+0x10 -> ack with data 0.
- Wrap and reset mid-op: preload count to 0xFFFFFFFF, write DATA -> count=0. Assert reset during the ACK cycle -> ack drops asynchronously and user_data_out=C_RESET_VALUE.
- Macro on: write 0xCAFEF00D to 0x0 -> user_data_out unchanged, readback 0xCAFEF00D, no valid pulse. Write 0x8 -> user_data_out=0xCAFEF00D, one valid pulse, count+1.
